affinex_point_fifo: RTL and testbench
=====================================

// Module: affinex_point_fifo
// PURPOSE
//  Paired X/Y input point buffer feeding the affine transform engine in FIFO mode.
//  Bus writes to FIFO_XIN/FIFO_YIN (0x30/0x34) are assembled into {x,y} points and queued.
//  The engine pops one point per transform through a valid/ready handshake.
//  Occupancy and sticky error flags are exported for the STATUS register.
// PARAMETERS
//  WIDTH      16  signed Q8.8 coordinate width
//  DEPTH      4   entries; power of two, >= 2
//  IRQ_LEVEL  2   occupancy threshold for irq (used only with AFFINEX_FIFO_IRQ_EN)
// PORTS
//  clk        in   1                project clock
//  rst_n      in   1                asynchronous active-low reset
//  wr_x       in   1                1-cycle strobe: bus write to FIFO_XIN
//  wr_y       in   1                1-cycle strobe: bus write to FIFO_YIN
//  wr_data    in   WIDTH            data_in[WIDTH-1:0] for wr_x/wr_y
//  flush      in   1                synchronous queue clear (CONTROL bit)
//  clr_err    in   1                clears overflow and pair_err
//  pt_valid   out  1                head entry available
//  pt_ready   in   1                engine accepts head this cycle
//  pt_x       out  WIDTH            head X (show-ahead)
//  pt_y       out  WIDTH            head Y (show-ahead)
//  count      out  $clog2(DEPTH)+1  entries stored
//  full       out  1                count == DEPTH
//  empty      out  1                count == 0
//  x_pending  out  1                X held, waiting for its Y
//  overflow   out  1                sticky: Y write dropped because full
//  pair_err   out  1                sticky: Y write with no pending X
//  irq        out  1                level interrupt (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: pointers, count, x_hold, x_pending, overflow, pair_err, irq = 0;
//    empty=1, full=0, pt_valid=0, pt_x=pt_y=0 (storage reset to 0).
//  - wr_x: x_hold <= wr_data, x_pending <= 1. wr_x while pending overwrites x_hold (no error).
//  - wr_y with x_pending & !full: push {x_hold, wr_data}, x_pending <= 0.
//  - wr_y with x_pending & full (and no pop this cycle): drop, overflow <= 1, x_pending stays 1.
//  - wr_y with !x_pending: drop, pair_err <= 1.
//  - wr_x and wr_y same cycle: illegal from bus; if it occurs wr_y is evaluated against the
//    old x_pending/x_hold, then wr_x loads x_hold and sets x_pending.
//  - Pop: pt_valid & pt_ready; pt_valid = !empty, combinational from count.
//  - Push latency: point written at edge N is on pt_x/pt_y with pt_valid=1 after edge N.
//  - Push+pop same cycle: both taken, count unchanged; when full the pop frees the slot and
//    the push is accepted (no overflow). When empty, no pop (pt_valid=0); push taken.
//  - Pointers wrap modulo DEPTH; count never exceeds DEPTH or goes below 0.
//  - flush: pointers, count, x_pending <= 0 next edge; overrides push/pop that cycle;
//    stickies untouched. clr_err clears stickies; a new error in the same cycle wins (sets).
//  - pt_x/pt_y stable while pt_valid=1 and pt_ready=0.
//  - Reset mid-operation: all state returns to reset values immediately (asynchronous).
// CONFIGURATION
//  AFFINEX_FIFO_IRQ_EN defined: irq registered, irq <= (count_next >= IRQ_LEVEL) | overflow;
//    asserts the cycle after the triggering push/error, drops after pop/flush/clr_err.
//  Undefined: irq tied 0; IRQ_LEVEL unused; no extra flops.
// TESTING
//  1 wr_x 0x0100, wr_y 0xFF00 -> next cycle pt_valid=1, pt_x=0x0100, pt_y=0xFF00, count=1.
//  2 5 X/Y pairs (DEPTH=4), pt_ready=0 -> full=1, count=4, overflow=1, x_pending=1 after 5th.
//  3 full, then wr_y with pt_ready=1 same cycle -> count stays 4, overflow=0, new tail stored.
//  4 wr_y 0x0010 with no prior wr_x -> pair_err=1, count=0; clr_err -> pair_err=0.
//  5 push 6 pops 6 interleaved -> pointer wrap, order preserved, empty=1 at end.
//  6 IRQ_EN, IRQ_LEVEL=2: 2 pushes -> irq=1; 1 pop -> irq=0; flush with 3 stored -> count=0, irq=0.

Source files
------------

// File: rtl/affinex_point_fifo_if.sv
// rtl/affinex_point_fifo_if.sv - bus-write, engine-pop and status bundle for the affine point FIFO
interface affinex_point_fifo_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             wr_x;
    logic             wr_y;
    logic [WIDTH-1:0] wr_data;
    logic             flush;
    logic             clr_err;
    logic             pt_valid;
    logic             pt_ready;
    logic [WIDTH-1:0] pt_x;
    logic [WIDTH-1:0] pt_y;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             x_pending;
    logic             overflow;
    logic             pair_err;
    logic             irq;

    modport master (
        output wr_x, wr_y, wr_data, flush, clr_err, pt_ready,
        input  pt_valid, pt_x, pt_y, count, full, empty, x_pending, overflow, pair_err, irq
    );

    modport slave (
        input  wr_x, wr_y, wr_data, flush, clr_err, pt_ready,
        output pt_valid, pt_x, pt_y, count, full, empty, x_pending, overflow, pair_err, irq
    );
endinterface

// File: rtl/affinex_point_fifo.sv
// rtl/affinex_point_fifo.sv - paired X/Y point queue feeding the affine engine (optional AFFINEX_FIFO_IRQ_EN)
module affinex_point_fifo #(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 4,
    parameter int IRQ_LEVEL = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    affinex_point_fifo_if.slave fifo
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || IRQ_LEVEL > DEPTH) begin : g_bad_cfg
        $error("affinex_point_fifo: bad DEPTH/IRQ_LEVEL");
    end

    logic [WIDTH-1:0] mem_x_q [DEPTH];
    logic [WIDTH-1:0] mem_y_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] x_hold_q, x_hold_d;
    logic             x_pending_q, x_pending_d;
    logic             overflow_q, overflow_d;
    logic             pair_err_q, pair_err_d;

    logic full, empty, pop, y_ok, push, wr_en, ovf_set, pair_set;

    always_comb begin
        full     = (count_q == CW'(DEPTH));
        empty    = (count_q == '0);
        pop      = !empty && fifo.pt_ready;
        // wr_y is judged against the X held before this edge, even if wr_x fires too
        y_ok     = fifo.wr_y && x_pending_q;
        push     = y_ok && (!full || pop);
        ovf_set  = y_ok && full && !pop;
        pair_set = fifo.wr_y && !x_pending_q;
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        wr_en       = 1'b0;
        x_hold_d    = x_hold_q;
        x_pending_d = x_pending_q;

        if (fifo.wr_x) begin
            x_hold_d = fifo.wr_data;
        end

        if (fifo.flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            x_pending_d = 1'b0;
        end else begin
            wr_en = push;
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(push) - CW'(pop);
            if (fifo.wr_x) begin
                x_pending_d = 1'b1;
            end else if (push) begin
                x_pending_d = 1'b0;
            end
        end

        // a fresh error in the clearing cycle must survive the clear
        overflow_d = ovf_set || (overflow_q && !fifo.clr_err);
        pair_err_d = pair_set || (pair_err_q && !fifo.clr_err);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            x_hold_q    <= '0;
            x_pending_q <= 1'b0;
            overflow_q  <= 1'b0;
            pair_err_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            x_hold_q    <= x_hold_d;
            x_pending_q <= x_pending_d;
            overflow_q  <= overflow_d;
            pair_err_q  <= pair_err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_x_q[i] <= '0;
                mem_y_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_x_q[wr_ptr_q] <= x_hold_q;
            mem_y_q[wr_ptr_q] <= fifo.wr_data;
        end
    end

`ifdef AFFINEX_FIFO_IRQ_EN
    logic irq_q, irq_d;

    always_comb begin
        irq_d = (count_d >= CW'(IRQ_LEVEL)) || overflow_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign fifo.irq = irq_q;
`else
    assign fifo.irq = 1'b0;
`endif

    assign fifo.pt_valid  = !empty;
    assign fifo.pt_x      = mem_x_q[rd_ptr_q];
    assign fifo.pt_y      = mem_y_q[rd_ptr_q];
    assign fifo.count     = count_q;
    assign fifo.full      = full;
    assign fifo.empty     = empty;
    assign fifo.x_pending = x_pending_q;
    assign fifo.overflow  = overflow_q;
    assign fifo.pair_err  = pair_err_q;
endmodule

// File: tb/tb_affinex_point_fifo.sv
// tb/tb_affinex_point_fifo.sv - directed self-checking bench for affinex_point_fifo
module tb_affinex_point_fifo;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

`ifdef AFFINEX_FIFO_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    affinex_point_fifo_if #(.WIDTH(16), .DEPTH(4)) bus ();

    affinex_point_fifo #(.WIDTH(16), .DEPTH(4), .IRQ_LEVEL(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fifo  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step(input logic wx, input logic wy, input logic [15:0] d,
                        input logic rdy, input logic fl, input logic ce);
        bus.wr_x     = wx;
        bus.wr_y     = wy;
        bus.wr_data  = d;
        bus.pt_ready = rdy;
        bus.flush    = fl;
        bus.clr_err  = ce;
        @(posedge clk);
        #1;
        bus.wr_x     = 1'b0;
        bus.wr_y     = 1'b0;
        bus.wr_data  = '0;
        bus.pt_ready = 1'b0;
        bus.flush    = 1'b0;
        bus.clr_err  = 1'b0;
    endtask

    task automatic push_pair(input logic [15:0] x, input logic [15:0] y);
        step(1'b1, 1'b0, x, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, y, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst_n        = 1'b0;
        bus.wr_x     = 1'b0;
        bus.wr_y     = 1'b0;
        bus.wr_data  = '0;
        bus.pt_ready = 1'b0;
        bus.flush    = 1'b0;
        bus.clr_err  = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        chk("rst_empty", bus.empty, 1);
        chk("rst_full", bus.full, 0);
        chk("rst_valid", bus.pt_valid, 0);
        chk("rst_count", bus.count, 0);
        chk("rst_pt_x", bus.pt_x, 0);
        chk("rst_pt_y", bus.pt_y, 0);
        chk("rst_xpend", bus.x_pending, 0);
        chk("rst_ovf", bus.overflow, 0);
        chk("rst_perr", bus.pair_err, 0);
        chk("rst_irq", bus.irq, 0);
        rst_n = 1'b1;

        // single pair, show-ahead latency
        step(1'b1, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
        chk("t1_xpend", bus.x_pending, 1);
        chk("t1_novalid", bus.pt_valid, 0);
        step(1'b0, 1'b1, 16'hFF00, 1'b0, 1'b0, 1'b0);
        chk("t1_valid", bus.pt_valid, 1);
        chk("t1_pt_x", bus.pt_x, 16'h0100);
        chk("t1_pt_y", bus.pt_y, 16'hFF00);
        chk("t1_count", bus.count, 1);
        chk("t1_xclr", bus.x_pending, 0);
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        chk("t1_pop_empty", bus.empty, 1);
        chk("t1_pop_count", bus.count, 0);

        // five pairs into four slots
        for (int i = 0; i < 5; i++) begin
            push_pair(16'h0010 + 16'(i), 16'h0020 + 16'(i));
            if (i == 3) begin
                chk("t2_full4", bus.full, 1);
                chk("t2_ovf_not_yet", bus.overflow, 0);
            end
        end
        chk("t2_full", bus.full, 1);
        chk("t2_count", bus.count, 4);
        chk("t2_ovf", bus.overflow, 1);
        chk("t2_xpend", bus.x_pending, 1);
        chk("t2_head_x", bus.pt_x, 16'h0010);
        chk("t2_head_y", bus.pt_y, 16'h0020);
        chk("t2_irq", bus.irq, IRQ_ON);

        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        chk("t3_ovf_clr", bus.overflow, 0);
        chk("t3_xpend_kept", bus.x_pending, 1);
        // push into a full queue while popping: X held from the dropped 5th pair is 0x0014
        step(1'b0, 1'b1, 16'h0AAA, 1'b1, 1'b0, 1'b0);
        chk("t3_count", bus.count, 4);
        chk("t3_ovf", bus.overflow, 0);
        chk("t3_xpend", bus.x_pending, 0);
        chk("t3_head_x", bus.pt_x, 16'h0011);
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        chk("t3_stable_x", bus.pt_x, 16'h0011);
        chk("t3_stable_y", bus.pt_y, 16'h0021);
        for (int i = 1; i < 4; i++) begin
            chk("t3_drain_x", bus.pt_x, 16'h0010 + 16'(i));
            chk("t3_drain_y", bus.pt_y, 16'h0020 + 16'(i));
            step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        end
        chk("t3_tail_x", bus.pt_x, 16'h0014);
        chk("t3_tail_y", bus.pt_y, 16'h0AAA);
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        chk("t3_empty", bus.empty, 1);
        chk("t3_irq", bus.irq, 0);

        // Y without X
        step(1'b0, 1'b1, 16'h0010, 1'b0, 1'b0, 1'b0);
        chk("t4_perr", bus.pair_err, 1);
        chk("t4_count", bus.count, 0);
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        chk("t4_perr_clr", bus.pair_err, 0);
        step(1'b0, 1'b1, 16'h0010, 1'b0, 1'b0, 1'b1);
        chk("t4_set_wins", bus.pair_err, 1);
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        chk("t4_perr_clr2", bus.pair_err, 0);

        // six points through with concurrent push/pop, crossing the pointer wrap
        push_pair(16'h0A00, 16'h0B00);
        for (int i = 1; i < 6; i++) begin
            step(1'b1, 1'b0, 16'h0A00 + 16'(i), 1'b0, 1'b0, 1'b0);
            chk("t5_head_x", bus.pt_x, 16'h0A00 + 16'(i - 1));
            chk("t5_head_y", bus.pt_y, 16'h0B00 + 16'(i - 1));
            step(1'b0, 1'b1, 16'h0B00 + 16'(i), 1'b1, 1'b0, 1'b0);
            chk("t5_count", bus.count, 1);
        end
        chk("t5_last_x", bus.pt_x, 16'h0A05);
        chk("t5_last_y", bus.pt_y, 16'h0B05);
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        chk("t5_empty", bus.empty, 1);

        // irq threshold and flush
        push_pair(16'h0001, 16'h0002);
        chk("t6_irq_1", bus.irq, 0);
        push_pair(16'h0003, 16'h0004);
        chk("t6_irq_2", bus.irq, IRQ_ON);
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        chk("t6_irq_pop", bus.irq, 0);
        push_pair(16'h0005, 16'h0006);
        push_pair(16'h0007, 16'h0008);
        chk("t6_count3", bus.count, 3);
        chk("t6_irq_3", bus.irq, IRQ_ON);
        step(1'b1, 1'b0, 16'h0009, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'h000A, 1'b1, 1'b1, 1'b0);
        chk("t6_flush_count", bus.count, 0);
        chk("t6_flush_empty", bus.empty, 1);
        chk("t6_flush_xpend", bus.x_pending, 0);
        chk("t6_flush_irq", bus.irq, 0);

        // asynchronous reset mid-operation
        push_pair(16'h1234, 16'h5678);
        chk("t7_count_pre", bus.count, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t7_async_count", bus.count, 0);
        chk("t7_async_valid", bus.pt_valid, 0);
        chk("t7_async_x", bus.pt_x, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
